// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor.
// Works through CHUNK bits per clock, LSB chunk first, over N = WIDTH/CHUNK
// RUN cycles. The carry between chunks is held in a register. Operands are
// taken with start, and the result is announced by a one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand/result width (a multiple of CHUNK, minimum 4)
//   CHUNK  bits processed per cycle (1..WIDTH)
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  request an operation; sampled in IDLE or DONE
//   M      mode: 0 = A+B, 1 = A-B; sampled with start
//   A, B   operands; sampled with start
//   busy   high while an operation is in RUN
//   done   one-cycle pulse; S/Co/V have just been updated
//   S      result; holds its value until the next done
//   Co     carry out of the MSB (for subtract, 1 = no borrow)
//   V      signed overflow
// Build option:
//   ADDSUB_SAT_EN  when defined, S is clamped to the signed extreme on overflow
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             M,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // B already inverted for subtract
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_amsb;
  logic             r_bmsb;
  logic [WIDTH-1:0] r_S;
  logic             r_Co;
  logic             r_V;

  logic             w_load;
  logic             w_last;
  int unsigned      w_base;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_v;
  logic [WIDTH-1:0] w_s_final;

  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last = (r_cnt == CW'(N - 1));
  assign w_base = int'(r_cnt) * CHUNK;

  always_comb begin
    w_sum = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
          + {{CHUNK{1'b0}}, r_c};
    w_res = r_res;
    w_res[w_base +: CHUNK] = w_sum[CHUNK-1:0];
  end

  // Only meaningful on the last chunk, where w_sum[CHUNK-1] is the result MSB.
  assign w_v = (r_amsb == r_bmsb) && (w_sum[CHUNK-1] != r_amsb);

`ifdef ADDSUB_SAT_EN
  always_comb begin
    w_s_final = w_res;
    if (w_v) begin
      w_s_final = r_amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_s_final = w_res;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_S     <= '0;
      r_Co    <= 1'b0;
      r_V     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_a    <= A;
        r_b    <= B ^ {WIDTH{M}};
        r_c    <= M;
        r_cnt  <= '0;
        r_amsb <= A[WIDTH-1];
        r_bmsb <= B[WIDTH-1] ^ M;
      end else if (r_state == RUN) begin
        r_res <= w_res;
        r_c   <= w_sum[CHUNK];
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_S  <= w_s_final;
          r_Co <= w_sum[CHUNK];
          r_V  <= w_v;
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign S    = r_S;
  assign Co   = r_Co;
  assign V    = r_V;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: one 16/4 instance for directed and randomized
// operations, plus 4-bit instances with CHUNK 1, 2 and 4 swept exhaustively.
// A cycle-level behavioural model predicts busy/done/S/Co/V for every
// instance and is compared against the DUTs on every falling edge.
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT inputs
  logic        st0 = 1'b0, m0 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0;
  logic        st1 = 1'b0, m1 = 1'b0, st2 = 1'b0, m2 = 1'b0, st3 = 1'b0, m3 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0, a2 = '0, b2 = '0, a3 = '0, b3 = '0;
  // DUT outputs
  logic        busy0, busy1, busy2, busy3, done0, done1, done2, done3;
  logic        co0, co1, co2, co3, v0, v1, v2, v3;
  logic [15:0] s0;
  logic [3:0]  s1, s2, s3;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .rst(rst), .start(st0), .M(m0),
    .A(a0), .B(b0), .busy(busy0), .done(done0), .S(s0), .Co(co0), .V(v0));
  addsub_seq #(.WIDTH(4), .CHUNK(1)) u1 (.clk(clk), .rst(rst), .start(st1), .M(m1),
    .A(a1), .B(b1), .busy(busy1), .done(done1), .S(s1), .Co(co1), .V(v1));
  addsub_seq #(.WIDTH(4), .CHUNK(2)) u2 (.clk(clk), .rst(rst), .start(st2), .M(m2),
    .A(a2), .B(b2), .busy(busy2), .done(done2), .S(s2), .Co(co2), .V(v2));
  addsub_seq #(.WIDTH(4), .CHUNK(4)) u3 (.clk(clk), .rst(rst), .start(st3), .M(m3),
    .A(a3), .B(b3), .busy(busy3), .done(done3), .S(s3), .Co(co3), .V(v3));

  localparam int W[4]    = '{16, 4, 4, 4};
  localparam int NCYC[4] = '{4, 4, 2, 1};

  logic        in_st[4], in_m[4];
  logic [15:0] in_a[4], in_b[4];
  logic        d_busy[4], d_done[4], d_Co[4], d_V[4];
  logic [15:0] d_S[4];
  logic [17:0] w_ref[4];

  always_comb begin
    in_st[0] = st0; in_m[0] = m0; in_a[0] = a0;          in_b[0] = b0;
    in_st[1] = st1; in_m[1] = m1; in_a[1] = {12'h0, a1}; in_b[1] = {12'h0, b1};
    in_st[2] = st2; in_m[2] = m2; in_a[2] = {12'h0, a2}; in_b[2] = {12'h0, b2};
    in_st[3] = st3; in_m[3] = m3; in_a[3] = {12'h0, a3}; in_b[3] = {12'h0, b3};
    d_busy[0] = busy0; d_busy[1] = busy1; d_busy[2] = busy2; d_busy[3] = busy3;
    d_done[0] = done0; d_done[1] = done1; d_done[2] = done2; d_done[3] = done3;
    d_Co[0] = co0; d_Co[1] = co1; d_Co[2] = co2; d_Co[3] = co3;
    d_V[0] = v0; d_V[1] = v1; d_V[2] = v2; d_V[3] = v3;
    d_S[0] = s0; d_S[1] = {12'h0, s1}; d_S[2] = {12'h0, s2}; d_S[3] = {12'h0, s3};
  end

  // Reference arithmetic from plain integers: returns {V, Co, S}.
  function automatic logic [17:0] ref_op(int w, logic [15:0] a, logic [15:0] b, logic m);
    longint mask, half, av, bv, raw, s, sa, sb, tr;
    logic co, v;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av   = longint'(a) & mask;
    bv   = longint'(b) & mask;
    raw  = av + (m ? (~bv & mask) : bv) + longint'(m);
    co   = ((raw >> w) & 1) != 0;
    s    = raw & mask;
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    tr   = m ? sa - sb : sa + sb;
    v    = (tr > half - 1) || (tr < -half);
`ifdef ADDSUB_SAT_EN
    if (v) s = (tr > 0) ? half - 1 : half;
`endif
    return {v, co, 16'(s)};
  endfunction

  always_comb for (int k = 0; k < 4; k++) w_ref[k] = ref_op(W[k], in_a[k], in_b[k], in_m[k]);

  // Handshake model: remaining RUN cycles, pending result, visible outputs.
  int          m_rem[4]   = '{0, 0, 0, 0};
  int          acc_cnt[4] = '{0, 0, 0, 0};
  logic        m_done[4]  = '{0, 0, 0, 0};
  logic [15:0] m_S[4]     = '{0, 0, 0, 0};
  logic [15:0] p_S[4]     = '{0, 0, 0, 0};
  logic        m_Co[4]    = '{0, 0, 0, 0};
  logic        m_V[4]     = '{0, 0, 0, 0};
  logic        p_Co[4]    = '{0, 0, 0, 0};
  logic        p_V[4]     = '{0, 0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_rem[k] <= 0; m_done[k] <= 1'b0;
        m_S[k] <= '0; m_Co[k] <= 1'b0; m_V[k] <= 1'b0;
      end else if (m_rem[k] > 0) begin
        m_rem[k]  <= m_rem[k] - 1;
        m_done[k] <= (m_rem[k] == 1);
        if (m_rem[k] == 1) begin
          m_S[k] <= p_S[k]; m_Co[k] <= p_Co[k]; m_V[k] <= p_V[k];
        end
      end else begin
        m_done[k] <= 1'b0;
        if (in_st[k]) begin
          p_S[k]     <= w_ref[k][15:0];
          p_Co[k]    <= w_ref[k][16];
          p_V[k]     <= w_ref[k][17];
          m_rem[k]   <= NCYC[k];
          acc_cnt[k] <= acc_cnt[k] + 1;
        end
      end
    end
  end

  task automatic chk(string name, int k, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(string name, int k);
    checks++;
    errors++;
    $display("FAIL %s inst%0d timed out at %0t", name, k, $time);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk("busy", k, d_busy[k], m_rem[k] > 0);
      chk("done", k, d_done[k], m_done[k]);
      chk("S",    k, d_S[k],    m_S[k]);
      chk("Co",   k, d_Co[k],   m_Co[k]);
      chk("V",    k, d_V[k],    m_V[k]);
    end
  end

  task automatic set_in(int k, logic st, logic m, logic [15:0] a, logic [15:0] b);
    case (k)
      0: begin st0 = st; m0 = m; a0 = a;      b0 = b;      end
      1: begin st1 = st; m1 = m; a1 = a[3:0]; b1 = b[3:0]; end
      2: begin st2 = st; m2 = m; a2 = a[3:0]; b2 = b[3:0]; end
      default: begin st3 = st; m3 = m; a3 = a[3:0]; b3 = b[3:0]; end
    endcase
  endtask

  // Raise start until the model records acceptance, then drop it.
  task automatic op_start(int k, logic [15:0] a, logic [15:0] b, logic m);
    int c0;
    bit ok;
    c0 = acc_cnt[k];
    ok = 1'b0;
    @(posedge clk); #2;
    set_in(k, 1'b1, m, a, b);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acc_cnt[k] != c0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("accept", k);
    #1 set_in(k, 1'b0, m, a, b);
  endtask

  task automatic wait_done(int k);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_done[k]) return;
    end
    fail_timeout("done", k);
  endtask

  task automatic run_lit(string nm, logic [15:0] a, logic [15:0] b, logic m,
                         logic [15:0] es, logic eco, logic ev);
    op_start(0, a, b, m);
    wait_done(0);
    chk({nm, "_S"},  0, d_S[0],  es);
    chk({nm, "_Co"}, 0, d_Co[0], eco);
    chk({nm, "_V"},  0, d_V[0],  ev);
  endtask

  task automatic sweep(int k);
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op_start(k, 16'(a), 16'(b), 1'(m));
    wait_done(k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    logic [15:0] ovf_pos, ovf_neg;
`ifdef ADDSUB_SAT_EN
    ovf_pos = 16'h7FFF; ovf_neg = 16'h8000;
`else
    ovf_pos = 16'h8000; ovf_neg = 16'h7FFF;
`endif
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_S", 0, d_S[0], 0);
    chk("rst_busy", 0, d_busy[0], 0);
    chk("rst_done", 0, d_done[0], 0);

    // Pin the reference model with hand-computed values.
    chk("ref_add",  0, ref_op(16, 16'h1234, 16'h0FFF, 1'b0), {2'b00, 16'h2233});
    chk("ref_sub",  0, ref_op(16, 16'h0005, 16'h0007, 1'b1), {2'b00, 16'hFFFE});
    chk("ref_ovf",  0, ref_op(16, 16'h7FFF, 16'h0001, 1'b0), {2'b10, ovf_pos});
    chk("ref_ovf4", 1, ref_op(4, 16'h0007, 16'h0001, 1'b0), {2'b10, 12'h0, ovf_pos[15:12]});

    run_lit("add1",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_lit("addc",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_lit("subb",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_lit("sub",   16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_lit("ovfa",  16'h7FFF, 16'h0001, 1'b0, ovf_pos,  1'b0, 1'b1);
    run_lit("ovfs",  16'h8000, 16'h0001, 1'b1, ovf_neg,  1'b1, 1'b1);

    // start pulsed while busy with other operands must be ignored
    op_start(0, 16'h1234, 16'h0FFF, 1'b0);
    @(posedge clk); #2 set_in(0, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    @(posedge clk); #2 set_in(0, 1'b0, 1'b1, 16'hAAAA, 16'h5555);
    wait_done(0);
    chk("ignore_S", 0, d_S[0], 16'h2233);

    // start held through DONE: second done five cycles after the first
    @(posedge clk); #2 set_in(0, 1'b1, 1'b0, 16'h0001, 16'h0002);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_done[0]) begin seen = 1'b1; break; end
    end
    if (!seen) fail_timeout("b2b_first", 0);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (d_done[0]) begin seen = 1'b1; break; end
    end
    set_in(0, 1'b0, 1'b0, 16'h0001, 16'h0002);
    if (!seen) fail_timeout("b2b_second", 0);
    else chk("b2b_gap", 0, n, 5);

    // reset during the second RUN cycle aborts the operation
    op_start(0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("abort_S",    0, d_S[0],    0);
    chk("abort_Co",   0, d_Co[0],   0);
    chk("abort_V",    0, d_V[0],    0);
    chk("abort_busy", 0, d_busy[0], 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(posedge clk);

    // randomized operations with operand churn and start pulses during RUN
    for (int t = 0; t < 150; t++) begin
      op_start(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      for (int j = 0; j < NCYC[0] - 1; j++) begin
        @(posedge clk); #2
        set_in(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               16'($urandom), 16'($urandom));
      end
      @(posedge clk); #2 set_in(0, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      wait_done(0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    fork
      sweep(1);
      sweep(2);
      sweep(3);
    join

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
